// File: rtl/emc_sram_arbiter.sv
// emc_sram_arbiter: shares the external async SRAM bus between two fabric
// requesters with round-robin grant and setup/strobe/hold/turn sequencing.
module emc_sram_arbiter #(
   parameter int AW      = 26,
   parameter int DW      = 16,
   parameter int WAIT_RD = 2,
   parameter int WAIT_WR = 2
) (
   input  logic          FAB_CLK,
   input  logic          FAB_RESET,
   input  logic          REQ0,
   input  logic          REQ1,
   input  logic          WE0,
   input  logic          WE1,
   input  logic [AW-1:0] ADDR0,
   input  logic [AW-1:0] ADDR1,
   input  logic [DW-1:0] WDATA0,
   input  logic [DW-1:0] WDATA1,
   input  logic [1:0]    BE0,
   input  logic [1:0]    BE1,
   output logic          ACK0,
   output logic          ACK1,
   output logic [DW-1:0] RDATA,
   output logic [AW-1:0] SRAM_AB,
   output logic [1:0]    SRAM_BYTEN_N,
   output logic          SRAM_CS_N,
   output logic          SRAM_OE_N,
   output logic          SRAM_WE_N,
   output logic [DW-1:0] SRAM_DB_O,
   output logic          SRAM_DB_OE,
   input  logic [DW-1:0] SRAM_DB_I
);

   // zero wait states would leave no strobe at all, so clamp to one
   localparam logic [3:0] LP_RD = (WAIT_RD < 1) ? 4'd1 : 4'(WAIT_RD);
   localparam logic [3:0] LP_WR = (WAIT_WR < 1) ? 4'd1 : 4'(WAIT_WR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_TURN
   } state_t;

   state_t        r_state;
   state_t        w_state;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt;
   logic          r_ptr;
   logic          w_ptr;
   logic          r_gnt;
   logic          w_gnt;
   logic          r_we;
   logic          w_we;
   logic          r_ack0;
   logic          w_ack0;
   logic          r_ack1;
   logic          w_ack1;
   logic [DW-1:0] r_rdata;
   logic [AW-1:0] r_ab;
   logic [AW-1:0] w_ab;
   logic [1:0]    r_byten_n;
   logic [1:0]    w_byten_n;
   logic          r_cs_n;
   logic          w_cs_n;
   logic          r_oe_n;
   logic          w_oe_n;
   logic          r_we_n;
   logic          w_we_n;
   logic [DW-1:0] r_db_o;
   logic [DW-1:0] w_db_o;
   logic          r_db_oe;
   logic          w_db_oe;

   logic          w_sel;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic [1:0]    w_sel_be;
   logic          w_last_strobe;

   // r_ptr = 1 means requester 1 wins a tie
   assign w_sel       = REQ1 & (~REQ0 | r_ptr);
   assign w_sel_we    = w_sel ? WE1    : WE0;
   assign w_sel_addr  = w_sel ? ADDR1  : ADDR0;
   assign w_sel_wdata = w_sel ? WDATA1 : WDATA0;
   assign w_sel_be    = w_sel ? BE1    : BE0;

   assign w_last_strobe = (r_state == S_STROBE) && (r_cnt <= 4'd1);

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_ptr     = r_ptr;
      w_gnt     = r_gnt;
      w_we      = r_we;
      w_ack0    = 1'b0;
      w_ack1    = 1'b0;
      w_ab      = r_ab;
      w_byten_n = r_byten_n;
      w_cs_n    = r_cs_n;
      w_oe_n    = r_oe_n;
      w_we_n    = r_we_n;
      w_db_o    = r_db_o;
      w_db_oe   = r_db_oe;
      unique case (r_state)
         S_IDLE: begin
            if (REQ0 | REQ1) begin
               w_state   = S_SETUP;
               w_gnt     = w_sel;
               w_ptr     = ~w_sel;
               w_we      = w_sel_we;
               w_ab      = w_sel_addr;
               w_byten_n = ~w_sel_be;
               w_cs_n    = 1'b0;
               w_oe_n    = 1'b1;
               w_we_n    = 1'b1;
               w_db_oe   = w_sel_we;
               w_cnt     = w_sel_we ? LP_WR : LP_RD;
               if (w_sel_we) begin
                  w_db_o = w_sel_wdata;
               end
            end
         end
         S_SETUP: begin
            w_state = S_STROBE;
            w_oe_n  = r_we;
            w_we_n  = ~r_we;
         end
         S_STROBE: begin
            if (r_cnt <= 4'd1) begin
               w_state = S_HOLD;
               w_oe_n  = 1'b1;
               w_we_n  = 1'b1;
            end else begin
               w_cnt = r_cnt - 4'd1;
            end
         end
         S_HOLD: begin
            w_state   = S_TURN;
            w_cs_n    = 1'b1;
            w_db_oe   = 1'b0;
            w_byten_n = 2'b11;
            w_ack0    = ~r_gnt;
            w_ack1    = r_gnt;
         end
         S_TURN: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge FAB_CLK) begin
      if (FAB_RESET) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_ptr     <= 1'b0;
         r_gnt     <= 1'b0;
         r_we      <= 1'b0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_rdata   <= '0;
         r_ab      <= '0;
         r_byten_n <= 2'b11;
         r_cs_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_we_n    <= 1'b1;
         r_db_o    <= '0;
         r_db_oe   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_ptr     <= w_ptr;
         r_gnt     <= w_gnt;
         r_we      <= w_we;
         r_ack0    <= w_ack0;
         r_ack1    <= w_ack1;
         r_ab      <= w_ab;
         r_byten_n <= w_byten_n;
         r_cs_n    <= w_cs_n;
         r_oe_n    <= w_oe_n;
         r_we_n    <= w_we_n;
         r_db_o    <= w_db_o;
         r_db_oe   <= w_db_oe;
         if (w_last_strobe && !r_we) begin
            r_rdata <= SRAM_DB_I;
         end
      end
   end

   assign ACK0         = r_ack0;
   assign ACK1         = r_ack1;
   assign RDATA        = r_rdata;
   assign SRAM_AB      = r_ab;
   assign SRAM_BYTEN_N = r_byten_n;
   assign SRAM_CS_N    = r_cs_n;
   assign SRAM_OE_N    = r_oe_n;
   assign SRAM_WE_N    = r_we_n;
   assign SRAM_DB_O    = r_db_o;
   assign SRAM_DB_OE   = r_db_oe;

endmodule

// File: tb/tb_emc_sram_arbiter.sv
// tb_emc_sram_arbiter: SRAM pin model, transaction-level reference model
// and directed scenarios for emc_sram_arbiter.
module tb_emc_sram_arbiter;

   localparam int AW = 26;
   localparam int DW = 16;
   localparam int WR = 2;
   localparam int WW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wd0, wd1;
   logic [1:0]    be0, be1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata;
   logic [AW-1:0] ab;
   logic [1:0]    byten_n;
   logic          cs_n, oe_n, we_n, db_oe;
   logic [DW-1:0] db_o, db_i;

   logic [15:0]   sram [0:4095];

   int vec = 0;
   int mis = 0;

   // bench-side statistics, written only by the monitor
   int cyc = 0;
   int a0_cnt = 0;
   int a1_cnt = 0;
   int oe_cnt = 0;
   int den_cnt = 0;
   int cs_fall = 0;
   int cs_fall_cyc = 0;
   int last_ack_cyc = 0;
   logic [1:0] we_bn = 2'b11;
   int ack_id[$];
   int ack_cyc[$];

   always #5 clk = ~clk;

   assign db_i = (!cs_n && !oe_n) ? sram[ab[11:0]] : 16'h0000;

   emc_sram_arbiter #(
      .AW(AW), .DW(DW), .WAIT_RD(WR), .WAIT_WR(WW)
   ) dut (
      .FAB_CLK(clk), .FAB_RESET(rst),
      .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
      .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wd0), .WDATA1(wd1),
      .BE0(be0), .BE1(be1), .ACK0(ack0), .ACK1(ack1), .RDATA(rdata),
      .SRAM_AB(ab), .SRAM_BYTEN_N(byten_n), .SRAM_CS_N(cs_n),
      .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_DB_O(db_o),
      .SRAM_DB_OE(db_oe), .SRAM_DB_I(db_i)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: SRAM array, statistics and per-cycle model comparison
   initial begin : mon
      int          m_valid, m_ph, m_w, m_gnt, m_last;
      logic        m_we;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_wd, m_rdata;
      logic [1:0]  m_be;
      logic        e_cs, e_oe, e_we, e_den, e_a0, e_a1;
      logic [1:0]  e_bn;
      logic        p_we_n, p_cs_n;
      logic [1:0]  p_bn;
      logic [AW-1:0] p_ab;
      logic [DW-1:0] p_db;
      foreach (sram[i]) sram[i] = 16'h0000;
      m_valid = 0; m_ph = -1; m_w = 0; m_gnt = 0; m_last = 1;
      m_we = 1'b0; m_addr = '0; m_wd = '0; m_rdata = '0; m_be = 2'b00;
      p_we_n = 1'b1; p_cs_n = 1'b1; p_bn = 2'b11; p_ab = '0; p_db = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (m_valid != 0) begin
            e_cs = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_den = 1'b0;
            e_bn = 2'b11; e_a0 = 1'b0; e_a1 = 1'b0;
            if (m_ph >= 1 && m_ph <= m_w + 2) begin
               e_cs = 1'b0; e_bn = ~m_be; e_den = m_we;
            end
            if (m_ph >= 2 && m_ph <= m_w + 1) begin
               e_oe = m_we; e_we = !m_we;
            end
            if (m_ph == m_w + 3) begin
               e_a0 = (m_gnt == 0); e_a1 = (m_gnt == 1);
            end
            chk("cs_n", cs_n, e_cs);
            chk("oe_n", oe_n, e_oe);
            chk("we_n", we_n, e_we);
            chk("byten_n", byten_n, e_bn);
            chk("db_oe", db_oe, e_den);
            chk("ack0", ack0, e_a0);
            chk("ack1", ack1, e_a1);
            chk("rdata", rdata, m_rdata);
            if (!e_cs) chk("ab", ab, m_addr);
            if (e_den) chk("db_o", db_o, m_wd);
         end
         if (ack0 === 1'b1) begin
            a0_cnt++; ack_id.push_back(0); ack_cyc.push_back(cyc);
            last_ack_cyc = cyc;
         end
         if (ack1 === 1'b1) begin
            a1_cnt++; ack_id.push_back(1); ack_cyc.push_back(cyc);
            last_ack_cyc = cyc;
         end
         if (oe_n === 1'b0) oe_cnt++;
         if (db_oe === 1'b1) den_cnt++;
         if (we_n === 1'b0) we_bn = byten_n;
         if (p_cs_n === 1'b1 && cs_n === 1'b0) begin
            cs_fall++; cs_fall_cyc = cyc;
         end
         // the part latches data on the rising edge of WE_N
         if (p_we_n === 1'b0 && we_n === 1'b1 && p_cs_n === 1'b0) begin
            if (!p_bn[0]) sram[p_ab[11:0]][7:0]  = p_db[7:0];
            if (!p_bn[1]) sram[p_ab[11:0]][15:8] = p_db[15:8];
         end
         p_we_n = we_n; p_cs_n = cs_n; p_bn = byten_n;
         p_ab = ab; p_db = db_o;
         if (rst === 1'b1) begin
            m_valid = 1; m_ph = -1; m_last = 1; m_rdata = '0;
         end else if (m_valid != 0) begin
            if (m_ph < 0) begin
               if (req0 || req1) begin
                  m_gnt  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
                  m_last = m_gnt;
                  m_we   = (m_gnt == 1) ? we1 : we0;
                  m_addr = (m_gnt == 1) ? addr1 : addr0;
                  m_wd   = (m_gnt == 1) ? wd1 : wd0;
                  m_be   = (m_gnt == 1) ? be1 : be0;
                  m_w    = m_we ? WW : WR;
                  m_ph   = 1;
               end
            end else if (m_ph == m_w + 3) begin
               m_ph = -1;
            end else begin
               if (m_ph == m_w + 1 && !m_we) m_rdata = sram[m_addr[11:0]];
               m_ph++;
            end
         end
      end
   end

   task automatic acc(input int id, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [1:0] b,
                      output int lat, output logic [DW-1:0] rd);
      logic got;
      if (id == 0) begin
         req0 = 1'b1; we0 = w; addr0 = a; wd0 = d; be0 = b;
      end else begin
         req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; be1 = b;
      end
      lat = 0; got = 1'b0; rd = '0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if ((id == 0 && ack0 === 1'b1) || (id == 1 && ack1 === 1'b1)) begin
            got = 1'b1; rd = rdata;
         end
      end
      chk("ack_arrives", got, 1'b1);
      @(posedge clk); #1;
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat, a0s, a1s, ocs, dcs, cfs, tack, n;
      logic [DW-1:0] rd;
      logic got;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0; be0 = 2'b00; be1 = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_oe_n", oe_n, 1'b1);
      chk("rst_we_n", we_n, 1'b1);
      chk("rst_byten", byten_n, 2'b11);
      chk("rst_db_oe", db_oe, 1'b0);
      chk("rst_ab", ab, 32'h0);
      chk("rst_db_o", db_o, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_ack", {ack1, ack0}, 2'b00);
      @(posedge clk); #1;

      // single write from requester 0
      a0s = a0_cnt; a1s = a1_cnt;
      acc(0, 1'b1, 26'h000123, 16'hBEEF, 2'b11, lat, rd);
      chk("wr_latency", lat, 6);
      chk("wr_mem", sram[12'h123], 16'hBEEF);
      chk("wr_ack0_once", a0_cnt - a0s, 1);
      chk("wr_ack1_none", a1_cnt - a1s, 0);

      // single read from requester 1
      ocs = oe_cnt; dcs = den_cnt;
      acc(1, 1'b0, 26'h000123, 16'h0000, 2'b11, lat, rd);
      chk("rd_data", rd, 16'hBEEF);
      chk("rd_oe_cycles", oe_cnt - ocs, 2);
      chk("rd_no_drive", den_cnt - dcs, 0);
      chk("rd_latency", lat, 6);

      // byte write over a known word
      acc(1, 1'b1, 26'h000200, 16'h1234, 2'b11, lat, rd);
      acc(0, 1'b1, 26'h000200, 16'hAA55, 2'b10, lat, rd);
      chk("bw_byten", we_bn, 2'b01);
      chk("bw_mem", sram[12'h200], 16'hAA34);

      // back-to-back reads from requester 0
      cfs = cs_fall;
      acc(0, 1'b0, 26'h000123, 16'h0000, 2'b11, lat, rd);
      tack = last_ack_cyc;
      chk("b2b_rd1", rd, 16'hBEEF);
      acc(0, 1'b0, 26'h000200, 16'h0000, 2'b11, lat, rd);
      chk("b2b_rd2", rd, 16'hAA34);
      chk("b2b_gap", cs_fall_cyc - tack, 2);
      chk("b2b_accesses", cs_fall - cfs, 2);

      // contention: last grant was requester 0, so requester 1 goes first
      n = ack_id.size();
      fork
         begin : c0
            int l0;
            logic [DW-1:0] r0;
            for (int i = 0; i < 4; i++)
               acc(0, 1'b1, 26'h300 + 26'(i), 16'h1000 + 16'(i), 2'b11, l0, r0);
         end
         begin : c1
            int l1;
            logic [DW-1:0] r1;
            for (int j = 0; j < 4; j++)
               acc(1, 1'b0, 26'h000123, 16'h0000, 2'b11, l1, r1);
         end
      join
      chk("rr_count", ack_id.size() - n, 8);
      if (ack_id.size() >= n + 8) begin
         for (int k = 0; k < 8; k++) begin
            chk("rr_order", ack_id[n+k], (k % 2 == 0) ? 1 : 0);
            if (k > 0) chk("rr_spacing", ack_cyc[n+k] - ack_cyc[n+k-1], 6);
         end
      end
      chk("rr_mem", sram[12'h303], 16'h1003);

      // reset while a write is strobing
      a0s = a0_cnt;
      req0 = 1'b1; we0 = 1'b1; addr0 = 26'h400; wd0 = 16'h5A5A; be0 = 2'b11;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (we_n === 1'b0) got = 1'b1;
      end
      chk("abort_in_strobe", got, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; req0 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", cs_n, 1'b1);
      chk("abort_we_n", we_n, 1'b1);
      chk("abort_db_oe", db_oe, 1'b0);
      chk("abort_rdata", rdata, 32'h0);
      repeat (8) @(negedge clk);
      chk("abort_no_ack", a0_cnt - a0s, 0);
      @(posedge clk); #1;
      n = ack_id.size();
      fork
         begin : p0
            int l2;
            logic [DW-1:0] r2;
            acc(0, 1'b0, 26'h000123, 16'h0000, 2'b11, l2, r2);
            chk("post_rst_rd", r2, 16'hBEEF);
         end
         begin : p1
            int l3;
            logic [DW-1:0] r3;
            acc(1, 1'b1, 26'h000500, 16'h7777, 2'b11, l3, r3);
         end
      join
      chk("post_rst_count", ack_id.size() - n, 2);
      if (ack_id.size() >= n + 2) begin
         chk("post_rst_first", ack_id[n], 0);
         chk("post_rst_second", ack_id[n+1], 1);
      end
      chk("post_rst_mem", sram[12'h500], 16'h7777);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
